// File: rtl/inst_fetch_if.sv
// Instruction-memory bus between the fetch unit (master) and the instruction memory (slave).
// Request is accepted on req&gnt; rvalid/rdata return exactly one cycle after acceptance.
interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: credit-limited requests, 2-entry {word, pc} FIFO, redirect flush.
// Optional macro IF_BYPASS_EN presents a response straight to the decoder when the FIFO is empty.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_fetch_if.master imem,
    input  logic         PCSel,
    input  logic [31:0]  alu_target,
    input  logic         stall,
    output logic [31:0]  inst,
    output logic [31:0]  inst_pc,
    output logic         inst_valid
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        r_run;
    logic [31:0] r_fetch_pc;
    logic [1:0]  r_count;
    logic        r_head;
    logic [1:0]  r_inflight;
    logic [1:0]  r_stale;
    logic [31:0] r_rsp_pc;
    logic [31:0] r_word [2];
    logic [31:0] r_pc   [2];

    logic [2:0]  w_credit;
    logic        w_accept;
    logic        w_rsp_live;
    logic        w_bypass;
    logic        w_pop;
    logic        w_push;
    logic        w_tail;

    // Credit uses registered occupancy only, so a pop never frees a slot in the same cycle.
    assign w_credit       = {1'b0, r_count} + {1'b0, r_inflight};
    assign imem.imem_req  = r_run & (w_credit < 3'd2) & ~PCSel;
    assign imem.imem_addr = r_fetch_pc;

    assign w_accept   = imem.imem_req & imem.imem_gnt;
    assign w_rsp_live = imem.imem_rvalid & (r_stale == 2'd0) & ~PCSel;
    assign w_pop      = (r_count != 2'd0) & ~stall & ~PCSel;
    assign w_tail     = r_head ^ r_count[0];

`ifdef IF_BYPASS_EN
    assign w_bypass = w_rsp_live & (r_count == 2'd0);
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word consumed by the decoder this cycle never enters the FIFO.
    assign w_push = w_rsp_live & ~(w_bypass & ~stall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_count    <= 2'd0;
            r_head     <= 1'b0;
            r_inflight <= 2'd0;
            r_stale    <= 2'd0;
        end else begin
            r_run      <= 1'b1;
            r_inflight <= r_inflight + {1'b0, w_accept} - {1'b0, imem.imem_rvalid};
            if (PCSel) begin
                r_count    <= 2'd0;
                r_fetch_pc <= {alu_target[31:2], 2'b00};
                r_stale    <= r_inflight - {1'b0, imem.imem_rvalid};
            end else begin
                if (w_accept)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (imem.imem_rvalid && (r_stale != 2'd0))
                    r_stale <= r_stale - 2'd1;
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
                if (w_pop)
                    r_head <= ~r_head;
            end
        end
    end

    // The response always belongs to the previous cycle's acceptance, so one pc register suffices.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_rsp_pc <= r_fetch_pc;
        if (w_push) begin
            r_word[w_tail] <= imem.imem_rdata;
            r_pc[w_tail]   <= r_rsp_pc;
        end
    end

    always_comb begin
        inst_valid = 1'b0;
        inst       = NOP;
        inst_pc    = 32'h0000_0000;
        if (r_count != 2'd0) begin
            inst_valid = 1'b1;
            inst       = r_word[r_head];
            inst_pc    = r_pc[r_head];
        end else if (w_bypass) begin
            inst_valid = 1'b1;
            inst       = imem.imem_rdata;
            inst_pc    = r_rsp_pc;
        end
    end
endmodule
